// File: rtl/bomba_duplex_ctrl.sv
// Duplex tank-fill pump sequencer: lead alternation, min-off / max-run enforcement, fault lockout.
// Optional feature macro: LAG_ASSIST_EN (lag pump assists while the level is still falling).
module bomba_duplex_ctrl #(
    parameter int MIN_OFF = 16,
    parameter int MAX_RUN = 1024,
    parameter int CNT_W   = 11
) (
    input  logic       ck,
    input  logic       rst_i,
    input  logic [2:0] sensores_i,
    input  logic       ack_i,
    output logic [1:0] bomba_o,
    output logic       lead_o,
    output logic [1:0] falla_o,
    output logic       alarma_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN_LEAD
`ifdef LAG_ASSIST_EN
        , RUN_BOTH
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       sens_p0, sens_p1;
    logic [2:0]       s;
    logic [CNT_W-1:0] off_cnt, off_nxt;
    logic [CNT_W-1:0] run_cnt, run_nxt;
    logic             lead_nxt;
    logic             incons, incons_lat, incons_set;
    logic             other_ok;
    logic [1:0]       fault_set;
    logic [1:0]       bomba_nxt;

    assign s        = sens_p1;
    assign incons   = (s[2] & ~s[1]) | (s[1] & ~s[0]);
    assign other_ok = ~falla_o[~lead_o];
    assign alarma_o = (|falla_o) | incons_lat;

    always_comb begin
        state_nxt  = state;
        lead_nxt   = lead_o;
        off_nxt    = off_cnt;
        run_nxt    = run_cnt;
        fault_set  = 2'b00;
        incons_set = 1'b0;
        case (state)
            IDLE: begin
                if (off_cnt != '0)
                    off_nxt = off_cnt - 1'b1;
                if (!s[1] && off_cnt == '0 && !incons && falla_o != 2'b11) begin
                    state_nxt = RUN_LEAD;
                    run_nxt   = '0;
                    // A faulted lead hands over to the healthy pump at start time.
                    if (falla_o[lead_o] && other_ok)
                        lead_nxt = ~lead_o;
                end
            end
            default: begin
                run_nxt = run_cnt + 1'b1;
                if (incons) begin
                    state_nxt  = IDLE;
                    incons_set = 1'b1;
                    off_nxt    = CNT_W'(MIN_OFF);
                end else if (s[2]) begin
                    state_nxt = IDLE;
                    off_nxt   = CNT_W'(MIN_OFF);
                    if (other_ok)
                        lead_nxt = ~lead_o;
                end else if (run_cnt == CNT_W'(MAX_RUN - 1)) begin
                    state_nxt          = IDLE;
                    off_nxt            = CNT_W'(MIN_OFF);
                    fault_set[lead_o]  = 1'b1;
                    if (other_ok)
                        lead_nxt = ~lead_o;
                end
`ifdef LAG_ASSIST_EN
                else if (state == RUN_LEAD && !s[0] && other_ok) begin
                    state_nxt = RUN_BOTH;
                end
`endif
            end
        endcase
    end

    always_comb begin
        bomba_nxt = 2'b00;
        if (state_nxt == RUN_LEAD)
            bomba_nxt = lead_nxt ? 2'b10 : 2'b01;
`ifdef LAG_ASSIST_EN
        else if (state_nxt == RUN_BOTH)
            bomba_nxt = 2'b11;
`endif
    end

    // Synchronizer stage and registered control state; reset drops the pumps immediately.
    always_ff @(posedge ck or posedge rst_i) begin
        if (rst_i) begin
            sens_p0    <= 3'b000;
            sens_p1    <= 3'b000;
            state      <= IDLE;
            off_cnt    <= CNT_W'(MIN_OFF);
            run_cnt    <= '0;
            lead_o     <= 1'b0;
            falla_o    <= 2'b00;
            incons_lat <= 1'b0;
            bomba_o    <= 2'b00;
        end else begin
            sens_p0    <= sensores_i;
            sens_p1    <= sens_p0;
            state      <= state_nxt;
            off_cnt    <= off_nxt;
            run_cnt    <= run_nxt;
            lead_o     <= lead_nxt;
            // A new fault outranks a simultaneous acknowledge.
            falla_o    <= (falla_o & ~{2{ack_i}}) | fault_set;
            if (incons_set)
                incons_lat <= 1'b1;
            else if (ack_i && !incons)
                incons_lat <= 1'b0;
            bomba_o    <= bomba_nxt;
        end
    end

endmodule

// File: tb/tb_bomba_duplex_ctrl.sv
// Self-checking bench for bomba_duplex_ctrl: directed scenarios plus randomized sensor traffic
// checked against a behavioural model of the pump sequencing rules.
module tb_bomba_duplex_ctrl;
    localparam int MIN_OFF = 4;
    localparam int MAX_RUN = 20;
    localparam int CNT_W   = 6;

    logic       ck = 1'b0;
    logic       rst_i = 1'b0;
    logic [2:0] sensores_i = 3'b000;
    logic       ack_i = 1'b0;
    logic [1:0] bomba_o, falla_o;
    logic       lead_o, alarma_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 ck = ~ck;

    bomba_duplex_ctrl #(.MIN_OFF(MIN_OFF), .MAX_RUN(MAX_RUN), .CNT_W(CNT_W)) dut (
        .ck(ck), .rst_i(rst_i), .sensores_i(sensores_i), .ack_i(ack_i),
        .bomba_o(bomba_o), .lead_o(lead_o), .falla_o(falla_o), .alarma_o(alarma_o)
    );

    // Behavioural model: pumps running (0/1/2), elapsed off time, on time since start.
    logic [2:0] m_q0, m_q1;
    int         m_mode, m_off, m_on;
    logic       m_lead, m_inc;
    logic [1:0] m_fault;

    function automatic void model_reset();
        m_q0 = 3'b000; m_q1 = 3'b000;
        m_mode = 0; m_off = 0; m_on = 0;
        m_lead = 1'b0; m_inc = 1'b0; m_fault = 2'b00;
    endfunction

    function automatic void model_edge(input logic [2:0] sens, input logic a);
        logic [2:0] s;
        logic       bad, oth;
        logic [1:0] nf;
        s   = m_q1;
        bad = (s[2] & ~s[1]) | (s[1] & ~s[0]);
        oth = ~m_lead;
        nf  = 2'b00;
        if (m_mode == 0) begin
            if (m_off >= MIN_OFF && !s[1] && !bad && m_fault != 2'b11) begin
                if (m_fault[m_lead] && !m_fault[oth]) m_lead = oth;
                m_mode = 1;
                m_on   = 0;
            end else if (m_off < MIN_OFF) begin
                m_off++;
            end
        end else if (bad) begin
            m_mode = 0; m_off = 0; m_inc = 1'b1;
        end else if (s[2]) begin
            m_mode = 0; m_off = 0;
            if (!m_fault[oth]) m_lead = oth;
        end else if (m_on == MAX_RUN - 1) begin
            m_mode = 0; m_off = 0; nf[m_lead] = 1'b1;
            if (!m_fault[oth]) m_lead = oth;
        end else begin
            m_on++;
`ifdef LAG_ASSIST_EN
            if (m_mode == 1 && !s[0] && !m_fault[oth]) m_mode = 2;
`endif
        end
        if (a) begin
            m_fault = 2'b00;
            if (!bad) m_inc = 1'b0;
        end
        m_fault = m_fault | nf;
        m_q1 = m_q0;
        m_q0 = sens;
    endfunction

    function automatic logic [5:0] m_out();
        logic [1:0] b;
        b = (m_mode == 0) ? 2'b00 : (m_mode == 2) ? 2'b11 : (m_lead ? 2'b10 : 2'b01);
        return {b, m_lead, m_fault, (|m_fault) | m_inc};
    endfunction

    task automatic tick();
        @(posedge ck);
        model_edge(sensores_i, ack_i);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({bomba_o, lead_o, falla_o, alarma_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_values got=%b required=000000", {bomba_o, lead_o, falla_o, alarma_o});
        end
        model_reset();
        @(posedge ck); @(posedge ck); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_fill_cycle();
        sensores_i = 3'b001;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (bomba_o !== ((i == 5) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL first_start edge%0d bomba got=%b", i, bomba_o);
            end
        end
        sensores_i = 3'b111;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (bomba_o !== ((i == 3) ? 2'b00 : 2'b01)) begin
                n_fail++;
                $display("FAIL full_stop edge%0d bomba got=%b", i, bomba_o);
            end
        end
        n_cmp++;
        if (lead_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lead_toggle got=%b required=1", lead_o);
        end
    endtask

    task automatic test_alternation();
        repeat (6) tick();
        sensores_i = 3'b001;
        repeat (3) tick();
        n_cmp++;
        if (bomba_o !== 2'b10) begin
            n_fail++;
            $display("FAIL alternate_start got=%b required=10", bomba_o);
        end
        sensores_i = 3'b000;
        repeat (3) tick();
        n_cmp++;
`ifdef LAG_ASSIST_EN
        if (bomba_o !== 2'b11) begin
            n_fail++;
            $display("FAIL lag_assist got=%b required=11", bomba_o);
        end
`else
        if (bomba_o !== 2'b10) begin
            n_fail++;
            $display("FAIL no_lag_assist got=%b required=10", bomba_o);
        end
`endif
        sensores_i = 3'b111;
        repeat (3) tick();
        n_cmp++;
        if ({bomba_o, lead_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL second_stop bomba/lead got=%b required=000", {bomba_o, lead_o});
        end
    endtask

    task automatic test_timeout();
        int on_a, on_b;
        on_a = 0; on_b = 0;
        repeat (6) tick();
        sensores_i = 3'b001;
        for (int i = 0; i < 55; i++) begin
            tick();
            if (bomba_o === 2'b01) on_a++;
            if (bomba_o === 2'b10) on_b++;
            n_cmp++;
            if ({bomba_o, lead_o, falla_o, alarma_o} !== m_out()) begin
                n_fail++;
                $display("FAIL timeout_model step%0d got=%b model=%b", i,
                         {bomba_o, lead_o, falla_o, alarma_o}, m_out());
            end
        end
        n_cmp++;
        if (on_a != MAX_RUN || on_b != MAX_RUN) begin
            n_fail++;
            $display("FAIL run_length pumpA=%0d pumpB=%0d required=%0d", on_a, on_b, MAX_RUN);
        end
        n_cmp++;
        if ({bomba_o, falla_o, alarma_o} !== 5'b00111) begin
            n_fail++;
            $display("FAIL double_fault got=%b required=00111", {bomba_o, falla_o, alarma_o});
        end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        n_cmp++;
        if ({falla_o, alarma_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL ack_clear got=%b required=000", {falla_o, alarma_o});
        end
        sensores_i = 3'b111;
        repeat (3) tick();
    endtask

    task automatic test_incons();
        repeat (6) tick();
        sensores_i = 3'b001;
        repeat (3) tick();
        sensores_i = 3'b101;
        repeat (3) tick();
        n_cmp++;
        if ({bomba_o, alarma_o} !== 3'b001) begin
            n_fail++;
            $display("FAIL incons_stop got=%b required=001", {bomba_o, alarma_o});
        end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        n_cmp++;
        if (alarma_o !== 1'b1) begin
            n_fail++;
            $display("FAIL incons_ack_held got=%b required=1", alarma_o);
        end
        sensores_i = 3'b111;
        repeat (3) tick();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        n_cmp++;
        if (alarma_o !== 1'b0) begin
            n_fail++;
            $display("FAIL incons_ack_clear got=%b required=0", alarma_o);
        end
    endtask

    task automatic test_async_reset();
        repeat (6) tick();
        sensores_i = 3'b001;
        repeat (3) tick();
        sensores_i = 3'b000;
        repeat (3) tick();
        n_cmp++;
        if (bomba_o !== m_out()[5:4] || bomba_o === 2'b00) begin
            n_fail++;
            $display("FAIL pre_reset_run got=%b model=%b", bomba_o, m_out()[5:4]);
        end
        #1 rst_i = 1'b1;
        #1;
        n_cmp++;
        if (bomba_o !== 2'b00) begin
            n_fail++;
            $display("FAIL async_drop got=%b required=00", bomba_o);
        end
        model_reset();
        @(posedge ck); @(posedge ck); #1;
        rst_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (bomba_o !== ((i == 5) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL restart_min_off edge%0d bomba got=%b", i, bomba_o);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] pats [4];
        int hold, r;
        pats[0] = 3'b000; pats[1] = 3'b001; pats[2] = 3'b011; pats[3] = 3'b111;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 9);
                sensores_i = (r < 9) ? pats[r % 4] : (($urandom_range(0, 1) == 0) ? 3'b101 : 3'b010);
                hold = $urandom_range(1, 30);
            end
            hold--;
            ack_i = ($urandom_range(0, 19) == 0);
            tick();
            n_cmp++;
            if ({bomba_o, lead_o, falla_o, alarma_o} !== m_out()) begin
                n_fail++;
                $display("FAIL random_model step%0d sens=%b got=%b model=%b", i, sensores_i,
                         {bomba_o, lead_o, falla_o, alarma_o}, m_out());
            end
        end
        ack_i = 1'b0;
    endtask

`ifndef LAG_ASSIST_EN
    task automatic test_single_pump();
        sensores_i = 3'b000;
        for (int i = 0; i < 80; i++) begin
            tick();
            n_cmp++;
            if (bomba_o === 2'b11 || bomba_o !== m_out()[5:4]) begin
                n_fail++;
                $display("FAIL single_pump step%0d got=%b model=%b", i, bomba_o, m_out()[5:4]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_cycle();
        test_alternation();
        test_timeout();
        test_incons();
        test_async_reset();
        test_random();
`ifndef LAG_ASSIST_EN
        test_single_pump();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
